muldiv_unit: RTL

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, sitting beside the ALU in the EX stage. It accepts one operation per start request and holds busy for a configurable latency so the hazard unit can stall mfhi/mflo and further HI/LO operations. Compared with the fixed 32-bit unit, it adds a width parameter, independent mul/div latencies, signed multiply-accumulate, a done pulse and flush/cancel on exceptions.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Ops are latched at the start edge. The result is computed from the latched
// operands and written on the edge that ends the last busy cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           r_state, w_state_nxt;
  op_e              r_op;
  op_e              w_op_in;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic             r_done;

  logic             w_load, w_commit, w_abort, w_is_mul, w_mthi, w_mtlo;

  logic [2*WIDTH-1:0] w_sprod, w_uprod, w_res;
  logic               w_a_neg, w_b_neg, w_sdiv;
  logic [WIDTH-1:0]   w_dvd, w_dvs, w_dvs_safe, w_q, w_r, w_div_hi, w_div_lo;

  assign w_op_in = op_e'(start);

  // Control FSM: accept ops only when idle and not flushing; count down while running.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    w_is_mul    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush) begin
          case (w_op_in)
            OP_MULT, OP_MULTU, OP_MADD: begin
              w_load = 1'b1; w_is_mul = 1'b1; w_state_nxt = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_load = 1'b1; w_state_nxt = S_RUN;
            end
            OP_MTHI: w_mthi = 1'b1;
            OP_MTLO: w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // flush wins even on the final cycle: the op never commits
        if (flush) begin
          w_abort = 1'b1; w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_commit = 1'b1; w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Operand/op latch and busy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op  <= OP_NONE;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_op  <= w_op_in;
      r_a   <= A;
      r_b   <= B;
      r_cnt <= w_is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
    end else if (w_abort) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Products: sign-extended operands give the signed product mod 2^(2W)
  assign w_sprod = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_uprod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Division on magnitudes so that MIN/-1 wraps cleanly instead of overflowing
  assign w_sdiv     = (r_op == OP_DIV);
  assign w_a_neg    = w_sdiv & r_a[WIDTH-1];
  assign w_b_neg    = w_sdiv & r_b[WIDTH-1];
  assign w_dvd      = w_a_neg ? -r_a : r_a;
  assign w_dvs      = w_b_neg ? -r_b : r_b;
  assign w_dvs_safe = (w_dvs == '0) ? WIDTH'(1) : w_dvs;
  assign w_q        = w_dvd / w_dvs_safe;
  assign w_r        = w_dvd % w_dvs_safe;
  assign w_div_lo   = (w_a_neg ^ w_b_neg) ? -w_q : w_q;
  assign w_div_hi   = w_a_neg ? -w_r : w_r;

  // Result selection at commit; divide by zero leaves HI/LO untouched
  always_comb begin
    w_res = {r_hi, r_lo};
    case (r_op)
      OP_MULT:  w_res = w_sprod;
      OP_MULTU: w_res = w_uprod;
      OP_MADD:  w_res = {r_hi, r_lo} + w_sprod;
      OP_DIV, OP_DIVU: if (r_b != '0) w_res = {w_div_hi, w_div_lo};
      default: ;
    endcase
  end

  // HI/LO registers and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        r_hi <= w_res[2*WIDTH-1:WIDTH];
        r_lo <= w_res[WIDTH-1:0];
      end else begin
        if (w_mthi) r_hi <= A;
        if (w_mtlo) r_lo <= A;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
